// File: rtl/branch_stack_pkg.sv
// ----------------------------------------------------------------------------
// branch_stack_pkg
// Shared types for the branch checkpoint stack: checkpoint entry layout,
// branch tag type and the physical-register sizing it depends on.
// The sizing macros (`N, `PHYS_REG_SZ_R10K, `NUM_SCALAR_BITS) normally come
// from the processor-wide defines; local fallbacks keep this block
// self-contained when it is built on its own.
// Optional feature macro used by branch_stack: BRANCH_STACK_PERF_EN.
// ----------------------------------------------------------------------------
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS $clog2(`N + 1)
`endif

package branch_stack_pkg;

    localparam int N_WAY           = `N;
    localparam int PHYS_REGS       = `PHYS_REG_SZ_R10K;
    localparam int PHYS_REG_IDX_SZ = $clog2(PHYS_REGS);
    localparam int NUM_SCALAR_BITS = `NUM_SCALAR_BITS;
    localparam int DEFAULT_DEPTH   = 4;

    typedef logic [PHYS_REG_IDX_SZ-1:0]     PHYS_REG_IDX;
    typedef logic [PHYS_REGS-1:0]           FREE_LIST;
    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] BRANCH_TAG;

    typedef struct packed {
        logic     valid;
        logic     resolved;
        FREE_LIST free_list;
    } CHECKPOINT_ENTRY;

endpackage

// File: rtl/branch_stack_retire_mask_decode.sv
// ----------------------------------------------------------------------------
// retire_mask_decode
// Turns the retiring T_old register list into a one-hot-per-register mask
// over the whole physical register file. Only the lowest num_retiring_valid
// entries of phys_reg_retiring are used.
// Ports:
//   phys_reg_retiring  in   N_WAY physical register indices freed by retire
//   num_retiring_valid in   count of valid entries, lowest indices first
//   retire_mask        out  bit r set when register r retires this cycle
// ----------------------------------------------------------------------------
module retire_mask_decode
    import branch_stack_pkg::*;
(
    input  PHYS_REG_IDX                phys_reg_retiring [N_WAY],
    input  logic [NUM_SCALAR_BITS-1:0] num_retiring_valid,
    output FREE_LIST                   retire_mask
);

    // NOTE: combinational outputs get a default before any conditional
    // assignment so no path leaves them unassigned (which would infer a latch).
    always_comb begin
        retire_mask = '0;
        for (int i = 0; i < N_WAY; i++) begin
            if (NUM_SCALAR_BITS'(i) < num_retiring_valid) begin
                retire_mask[phys_reg_retiring[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_stack.sv
// ----------------------------------------------------------------------------
// branch_stack
// Circular stack of free-list checkpoints, one per in-flight branch.
// Dispatch pushes a snapshot per branch; retiring registers are OR-ed into
// every live snapshot; correct resolves retire checkpoints in order from the
// head; a mispredict restores that branch's snapshot and squashes it and all
// younger checkpoints.
// Optional feature: define BRANCH_STACK_PERF_EN to add mispredict_count.
// Ports:
//   clock, reset           sole clock; synchronous active-high reset
//   push_valid/free_list   dispatch checkpoint request and its snapshot
//   push_tag, full         tag the next push receives; no free checkpoint
//   resolve_*              execute resolve: valid, tag, mispredict
//   phys_reg_retiring,
//   num_retiring_valid     registers freed by retire this cycle
//   free_list_restore,
//   restore_flag           snapshot and one-cycle strobe on mispredict
//   num_checkpoints        count of valid checkpoints
//   mispredict_count       (BRANCH_STACK_PERF_EN) saturating restore count
// ----------------------------------------------------------------------------
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  FREE_LIST                   push_free_list,
    output logic [$clog2(DEPTH)-1:0]   push_tag,
    output logic                       full,
    input  logic                       resolve_valid,
    input  logic [$clog2(DEPTH)-1:0]   resolve_tag,
    input  logic                       resolve_mispredict,
    input  PHYS_REG_IDX                phys_reg_retiring [N_WAY],
    input  logic [NUM_SCALAR_BITS-1:0] num_retiring_valid,
    output FREE_LIST                   free_list_restore,
    output logic                       restore_flag,
`ifdef BRANCH_STACK_PERF_EN
    output logic [31:0]                mispredict_count,
`endif
    output logic [$clog2(DEPTH):0]     num_checkpoints
);

    localparam int TAG_W = $clog2(DEPTH);
    localparam int CNT_W = TAG_W + 1;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [CNT_W-1:0] cnt_t;

    CHECKPOINT_ENTRY entry_q [DEPTH];
    CHECKPOINT_ENTRY entry_d [DEPTH];
    tag_t            head_q, head_d;
    tag_t            tail_q, tail_d;
    cnt_t            count_q, count_d;
    FREE_LIST        restore_q, restore_d;
    logic            flag_q, flag_d;

    FREE_LIST        retire_mask;
    logic            mispredict, correct, push_ok, advancing;
    tag_t            tgt_offset, scan_idx;
    cnt_t            live, adv;

    retire_mask_decode u_retire_mask_decode (
        .phys_reg_retiring  (phys_reg_retiring),
        .num_retiring_valid (num_retiring_valid),
        .retire_mask        (retire_mask)
    );

    assign full             = (count_q == cnt_t'(DEPTH));
    assign push_tag         = tail_q;
    assign num_checkpoints  = count_q;
    assign free_list_restore = restore_q;
    assign restore_flag     = flag_q;

    // Resolves naming an empty slot are ignored entirely.
    assign mispredict = resolve_valid &  resolve_mispredict & entry_q[resolve_tag].valid;
    assign correct    = resolve_valid & ~resolve_mispredict & entry_q[resolve_tag].valid;
    assign push_ok    = push_valid & ~full & ~mispredict;

    always_comb begin
        entry_d    = entry_q;
        tail_d     = tail_q;
        restore_d  = restore_q;
        flag_d     = 1'b0;
        live       = count_q;
        adv        = '0;
        advancing  = 1'b1;
        scan_idx   = '0;
        // Age of the resolving branch relative to the oldest checkpoint.
        tgt_offset = resolve_tag - head_q;

        // Snapshots only ever gain freed registers.
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_d[i].valid) begin
                entry_d[i].free_list = entry_d[i].free_list | retire_mask;
            end
        end

        if (correct) begin
            entry_d[resolve_tag].resolved = 1'b1;
        end

        if (mispredict) begin
            flag_d    = 1'b1;
            restore_d = entry_q[resolve_tag].free_list | retire_mask;
            // Squash the mispredicted branch and everything younger.
            for (int i = 0; i < DEPTH; i++) begin
                if (tag_t'(tag_t'(i) - head_q) >= tgt_offset) begin
                    entry_d[i] = '0;
                end
            end
            tail_d = resolve_tag;
            live   = cnt_t'(tgt_offset);
        end else if (push_ok) begin
            entry_d[tail_q] = '{valid: 1'b1, resolved: 1'b0,
                                free_list: push_free_list | retire_mask};
            tail_d = tail_q + 1'b1;
            live   = count_q + 1'b1;
        end

        // Retire the contiguous run of resolved checkpoints at the head,
        // including one resolved this very cycle.
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + tag_t'(k);
            if (advancing && (cnt_t'(k) < live) &&
                entry_d[scan_idx].valid && entry_d[scan_idx].resolved) begin
                entry_d[scan_idx] = '0;
                adv = adv + 1'b1;
            end else begin
                advancing = 1'b0;
            end
        end

        head_d  = head_q + tag_t'(adv);
        count_d = live - adv;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the snapshot storage is reset too, because a cleared
            // checkpoint must read back as an all-zero snapshot.
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            restore_q <= '0;
            flag_q    <= 1'b0;
        end else begin
            entry_q   <= entry_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            restore_q <= restore_d;
            flag_q    <= flag_d;
        end
    end

`ifdef BRANCH_STACK_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts each emitted restore strobe, sticking at all-ones.
    always_comb begin
        perf_d = perf_q;
        if (flag_q && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign mispredict_count = perf_q;
`endif

endmodule

// File: tb/tb_branch_stack.sv
// ----------------------------------------------------------------------------
// tb_branch_stack
// Directed bench for branch_stack (DEPTH = 4, default build). Expected
// restore snapshots are queued when a mispredict is driven and popped when
// the DUT raises restore_flag. Outputs are sampled 1 time unit after the
// rising edge.
// ----------------------------------------------------------------------------
module tb_branch_stack;
    import branch_stack_pkg::*;

    logic                       clock = 1'b0;
    logic                       reset;
    logic                       push_valid;
    FREE_LIST                   push_free_list;
    logic [1:0]                 push_tag;
    logic                       full;
    logic                       resolve_valid;
    logic [1:0]                 resolve_tag;
    logic                       resolve_mispredict;
    PHYS_REG_IDX                phys_reg_retiring [N_WAY];
    logic [NUM_SCALAR_BITS-1:0] num_retiring_valid;
    FREE_LIST                   free_list_restore;
    logic                       restore_flag;
    logic [2:0]                 num_checkpoints;

    int       checks = 0;
    int       errors = 0;
    FREE_LIST sb_q[$];

    branch_stack #(.DEPTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .push_valid         (push_valid),
        .push_free_list     (push_free_list),
        .push_tag           (push_tag),
        .full               (full),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .phys_reg_retiring  (phys_reg_retiring),
        .num_retiring_valid (num_retiring_valid),
        .free_list_restore  (free_list_restore),
        .restore_flag       (restore_flag),
        .num_checkpoints    (num_checkpoints)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input FREE_LIST obs, input FREE_LIST exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        push_valid         = 1'b0;
        push_free_list     = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_mispredict = 1'b0;
        num_retiring_valid = '0;
        for (int i = 0; i < N_WAY; i++) phys_reg_retiring[i] = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_push(input FREE_LIST snap, input int exp_tag);
        check("push_tag", FREE_LIST'(push_tag), FREE_LIST'(exp_tag));
        push_valid     = 1'b1;
        push_free_list = snap;
        tick();
        push_valid     = 1'b0;
        push_free_list = '0;
    endtask

    task automatic do_resolve(input int tag, input logic mis);
        resolve_valid      = 1'b1;
        resolve_tag        = 2'(tag);
        resolve_mispredict = mis;
        tick();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic expect_restore(input string name);
        FREE_LIST exp;
        check({name, "_flag"}, FREE_LIST'(restore_flag), FREE_LIST'(1));
        check({name, "_sb_pending"}, FREE_LIST'(sb_q.size() > 0), FREE_LIST'(1));
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check({name, "_value"}, free_list_restore, exp);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_count",   FREE_LIST'(num_checkpoints),   FREE_LIST'(0));
        check("rst_full",    FREE_LIST'(full),              FREE_LIST'(0));
        check("rst_tag",     FREE_LIST'(push_tag),          FREE_LIST'(0));
        check("rst_flag",    FREE_LIST'(restore_flag),      FREE_LIST'(0));
        check("rst_restore", free_list_restore,             FREE_LIST'(0));

        // ---------------- fill to full, overflow push ignored ----------------
        for (int i = 0; i < 4; i++) begin
            do_push(FREE_LIST'(64'h1 << i), i);
            check("fill_count", FREE_LIST'(num_checkpoints), FREE_LIST'(i + 1));
        end
        check("fill_full", FREE_LIST'(full), FREE_LIST'(1));
        do_push(FREE_LIST'(64'hDEAD), 0);
        check("ovf_count", FREE_LIST'(num_checkpoints), FREE_LIST'(4));
        check("ovf_full",  FREE_LIST'(full),            FREE_LIST'(1));
        check("ovf_tag",   FREE_LIST'(push_tag),        FREE_LIST'(0));

        // ---------------- snapshot gains retired register ----------------
        do_reset();
        do_push(FREE_LIST'(64'h00F0), 0);
        tick();
        phys_reg_retiring[0] = PHYS_REG_IDX'(2);
        num_retiring_valid   = NUM_SCALAR_BITS'(1);
        tick();
        clear_inputs();
        sb_q.push_back(FREE_LIST'(64'h00F4));
        do_resolve(0, 1'b1);
        expect_restore("mp_retire");
        check("mp_retire_count", FREE_LIST'(num_checkpoints), FREE_LIST'(0));
        check("mp_retire_tag",   FREE_LIST'(push_tag),        FREE_LIST'(0));
        tick();
        check("mp_flag_drop",    FREE_LIST'(restore_flag),    FREE_LIST'(0));
        check("mp_restore_hold", free_list_restore,           FREE_LIST'(64'h00F4));

        // Same-cycle retire on push and on mispredict both land in the snapshot.
        phys_reg_retiring[0] = PHYS_REG_IDX'(3);
        num_retiring_valid   = NUM_SCALAR_BITS'(1);
        do_push(FREE_LIST'(64'h0100), 0);
        phys_reg_retiring[0] = PHYS_REG_IDX'(5);
        phys_reg_retiring[1] = PHYS_REG_IDX'(9);
        num_retiring_valid   = NUM_SCALAR_BITS'(1);   // slot 1 must be ignored
        sb_q.push_back(FREE_LIST'(64'h0128));
        do_resolve(0, 1'b1);
        clear_inputs();
        expect_restore("mp_same_cycle");

        // ---------------- out-of-order correct resolves ----------------
        do_reset();
        for (int i = 0; i < 3; i++) do_push(FREE_LIST'(64'h10 << i), i);
        do_resolve(2, 1'b0);
        check("ooo_r2_count", FREE_LIST'(num_checkpoints), FREE_LIST'(3));
        do_resolve(1, 1'b0);
        check("ooo_r1_count", FREE_LIST'(num_checkpoints), FREE_LIST'(3));
        do_resolve(0, 1'b0);
        check("ooo_r0_count", FREE_LIST'(num_checkpoints), FREE_LIST'(0));
        check("ooo_r0_tag",   FREE_LIST'(push_tag),        FREE_LIST'(3));
        do_push(FREE_LIST'(64'h1), 3);
        check("ooo_wrap_tag", FREE_LIST'(push_tag),        FREE_LIST'(0));
        // Push and head retirement in the same cycle.
        push_valid     = 1'b1;
        push_free_list = FREE_LIST'(64'h2);
        resolve_valid  = 1'b1;
        resolve_tag    = 2'd3;
        tick();
        clear_inputs();
        check("net_count", FREE_LIST'(num_checkpoints), FREE_LIST'(1));
        check("net_tag",   FREE_LIST'(push_tag),        FREE_LIST'(1));

        // ---------------- mispredict beats simultaneous push ----------------
        do_reset();
        for (int i = 0; i < 4; i++) do_push(FREE_LIST'(64'h10 << i), i);
        push_valid     = 1'b1;
        push_free_list = FREE_LIST'(64'hBEEF);
        sb_q.push_back(FREE_LIST'(64'h20));
        do_resolve(1, 1'b1);
        clear_inputs();
        expect_restore("mp_push");
        check("mp_push_count", FREE_LIST'(num_checkpoints), FREE_LIST'(1));
        check("mp_push_tag",   FREE_LIST'(push_tag),        FREE_LIST'(1));
        check("mp_push_full",  FREE_LIST'(full),            FREE_LIST'(0));

        // ---------------- resolves of invalid tags ignored ----------------
        do_reset();
        do_push(FREE_LIST'(64'h3), 0);
        do_resolve(3, 1'b1);
        check("inv_flag",    FREE_LIST'(restore_flag),    FREE_LIST'(0));
        check("inv_restore", free_list_restore,           FREE_LIST'(0));
        check("inv_count",   FREE_LIST'(num_checkpoints), FREE_LIST'(1));
        check("inv_tag",     FREE_LIST'(push_tag),        FREE_LIST'(1));
        do_resolve(2, 1'b0);
        check("inv_ok_count", FREE_LIST'(num_checkpoints), FREE_LIST'(1));
        do_resolve(0, 1'b0);
        check("inv_ret_count", FREE_LIST'(num_checkpoints), FREE_LIST'(0));

        // ---------------- wrap-around and reset overriding restore ----------------
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_push(FREE_LIST'(64'h100 << i), i % 4);
            do_resolve(i % 4, 1'b0);
            check("wrap_count", FREE_LIST'(num_checkpoints), FREE_LIST'(0));
        end
        do_push(FREE_LIST'(64'h7), 2);
        reset = 1'b1;
        do_resolve(2, 1'b1);
        reset = 1'b0;
        check("rst_mp_flag",    FREE_LIST'(restore_flag),    FREE_LIST'(0));
        check("rst_mp_restore", free_list_restore,           FREE_LIST'(0));
        check("rst_mp_count",   FREE_LIST'(num_checkpoints), FREE_LIST'(0));
        check("rst_mp_tag",     FREE_LIST'(push_tag),        FREE_LIST'(0));
        do_push(FREE_LIST'(64'h5), 0);
        sb_q.push_back(FREE_LIST'(64'h5));
        do_resolve(0, 1'b1);
        expect_restore("pre_rst");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("post_rst_flag",    FREE_LIST'(restore_flag),    FREE_LIST'(0));
        check("post_rst_restore", free_list_restore,           FREE_LIST'(0));
        check("post_rst_count",   FREE_LIST'(num_checkpoints), FREE_LIST'(0));
        check("post_rst_full",    FREE_LIST'(full),            FREE_LIST'(0));

        check("sb_drained", FREE_LIST'(sb_q.size()), FREE_LIST'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_stack.md
BRANCH_STACK -- requirements
Module: branch_stack

Interface
REQ-001 Parameter DEPTH, default 4, number of branch checkpoints held (power of two, 2..16).
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 push_valid  input  1  dispatch allocates a checkpoint for a dispatched branch.
REQ-005 push_free_list  input  `PHYS_REG_SZ_R10K  free list after dispatch allocations up to and including the branch.
REQ-006 push_tag  output  $clog2(DEPTH)  tag the next accepted push receives (tail index).
REQ-007 full  output  1  no free checkpoint; dispatch holds branches while high.
REQ-008 resolve_valid  input  1  execute resolves one branch this cycle.
REQ-009 resolve_tag  input  $clog2(DEPTH)  tag of the resolving branch.
REQ-010 resolve_mispredict  input  1  resolving branch was mispredicted.
REQ-011 phys_reg_retiring  input  `N x PHYS_REG_IDX  T_old registers freed by retire.
REQ-012 num_retiring_valid  input  `NUM_SCALAR_BITS  count of valid phys_reg_retiring entries, lowest indices first.
REQ-013 free_list_restore  output  `PHYS_REG_SZ_R10K  snapshot driven to the free list on mispredict.
REQ-014 restore_flag  output  1  one-cycle mispredict restore strobe to the free list.
REQ-015 num_checkpoints  output  $clog2(DEPTH)+1  count of valid checkpoints.

Function
REQ-016 Storage is a circular buffer of DEPTH entries {valid, resolved, free_list} with head (oldest) and tail (next push) pointers, both wrapping modulo DEPTH.
REQ-017 Accepted push (push_valid & ~full & no mispredict this cycle) writes entry[tail] valid=1, resolved=0, free_list = push_free_list OR same-cycle retiring mask; tail increments.
REQ-018 Every cycle each valid entry ORs in the retiring mask (bits phys_reg_retiring[i] for i < num_retiring_valid); bits are never cleared in stored snapshots.
REQ-019 Correct resolve (resolve_valid & ~resolve_mispredict) on a valid entry sets resolved=1; out-of-order resolves are allowed.
REQ-020 Head advances past all contiguous valid&resolved entries in one cycle, clearing their valid bits.
REQ-021 Mispredict resolve on valid entry T: next cycle restore_flag=1 and free_list_restore = entry[T].free_list including same-cycle retiring mask; T and all younger entries invalidated; tail := T.
REQ-022 restore_flag is high exactly one cycle per mispredict; free_list_restore holds its last value otherwise.
REQ-023 Mispredict and push in the same cycle: mispredict wins, push dropped.
REQ-024 Resolve of an invalid tag is ignored, including mispredict (no restore_flag).
REQ-025 full = (num_checkpoints == DEPTH); push while full is ignored with no state change.
REQ-026 num_checkpoints updates the cycle after a push, retirement of resolved entries, or squash; simultaneous head advance and push net correctly.

Reset
REQ-027 On reset: head=tail=0, all valid/resolved=0, snapshots=0, full=0, num_checkpoints=0, push_tag=0, restore_flag=0, free_list_restore=0.
REQ-028 Reset asserted mid-operation, including the cycle after a mispredict, overrides every event; no restore_flag is emitted.

Configuration
REQ-029 Macro BRANCH_STACK_PERF_EN defined: extra output mispredict_count (32 bits) increments once per emitted restore_flag, cleared by reset, saturating at all-ones.
REQ-030 Macro undefined: no counter and no mispredict_count port; all other behaviour identical.

Structure
REQ-031 Shared package holds BRANCH_TAG typedef and the CHECKPOINT_ENTRY struct; PHYS_REG_IDX, `N, `PHYS_REG_SZ_R10K come from sys_defs.
REQ-032 One sub-module retire_mask_decode converts phys_reg_retiring/num_retiring_valid into the `PHYS_REG_SZ_R10K mask.

Verification
REQ-033 Reset, then 4 pushes (DEPTH=4) -> tags 0,1,2,3; full=1 after fourth; fifth push ignored, num_checkpoints=4.
REQ-034 Push snapshot 0x00F0 as tag 0, retire phys reg 2 two cycles later, mispredict tag 0 -> next cycle restore_flag=1, free_list_restore=0x00F4, num_checkpoints=0.
REQ-035 Tags 0,1,2 valid; correct-resolve 2 then 1 -> no head move; correct-resolve 0 -> head jumps to 3 in one cycle, num_checkpoints=0.
REQ-036 Tags 0..3 valid; mispredict tag 1 with simultaneous push -> push dropped, tail=1, num_checkpoints=1, push_tag=1.
REQ-037 Mispredict on invalid tag 3 when only tag 0 valid -> restore_flag stays 0, state unchanged.
REQ-038 Wrap-around: 6 push/resolve pairs in sequence -> tags 0,1,2,3,0,1; reset asserted the cycle after a mispredict -> restore_flag=0 and all outputs zero.
